inst_dispatcher: RTL and testbench

- Sequences the PE program: fetches instructions from the instruction memory, decodes the class field, and issues each one to the PE or the buffer unit over a valid/ready handshake.
- Implements SYNC barriers and HALT, and exposes program_counter and done for top_pe and the bench.
- Sits between u_instruction_memory and the PE/buffer datapaths inside top_pe.
- Replaces free-running PC logic with a start-triggered, count-bounded controller.

---
 rtl/dispatch_pkg.sv | 29 ++
 rtl/inst_dispatcher_if.sv | 30 +++
 rtl/defines.sv | 6 +
 rtl/inst_dispatcher.sv | 103 ++++++++++
 tb/tb_inst_dispatcher.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_pkg.sv
// ============================================================================
// dispatch_pkg : instruction class / dispatcher state encodings -- Rev 1.0
// ============================================================================
`default_nettype none
package dispatch_pkg;

    // Class field sits in the top two bits of a default-width instruction word.
    localparam int CLASS_MSB = 31;
    localparam int CLASS_LSB = 30;
    localparam int CLASS_W   = CLASS_MSB - CLASS_LSB + 1;

    typedef enum logic [1:0] {
        CLS_PE   = 2'b00,
        CLS_BUF  = 2'b01,
        CLS_SYNC = 2'b10,
        CLS_HALT = 2'b11
    } inst_class_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_SYNC_WAIT = 3'd4,
        ST_DONE      = 3'd5
    } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_dispatcher_if.sv
// ============================================================================
// inst_dispatcher_if : imem read bus plus PE/buffer issue handshake -- Rev 1.0
// ============================================================================
`default_nettype none
interface inst_dispatcher_if #(
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int INST_WIDTH      = 32
);
    logic                       imem_rd_en;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [INST_WIDTH-1:0]      imem_rdata;
    logic                       pe_inst_valid;
    logic                       pe_inst_ready;
    logic                       buf_inst_valid;
    logic                       buf_inst_ready;
    logic [INST_WIDTH-1:0]      inst_data;
    logic                       pe_idle;
    logic                       buf_idle;

    modport master (
        output imem_rd_en, imem_addr, pe_inst_valid, buf_inst_valid, inst_data,
        input  imem_rdata, pe_inst_ready, buf_inst_ready, pe_idle, buf_idle
    );

    modport slave (
        input  imem_rd_en, imem_addr, pe_inst_valid, buf_inst_valid, inst_data,
        output imem_rdata, pe_inst_ready, buf_inst_ready, pe_idle, buf_idle
    );
endinterface
`default_nettype wire

// File: rtl/defines.sv
// Global sizing macros shared by the PE subsystem.
`default_nettype none
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 8
`endif
`default_nettype wire

// File: rtl/inst_dispatcher.sv
// ============================================================================
// inst_dispatcher : start-triggered fetch/decode/issue controller -- Rev 1.0
// ============================================================================
`default_nettype none
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 8
`endif
module inst_dispatcher
    import dispatch_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = `IMEM_ADDR_WIDTH,
    parameter int INST_WIDTH      = CLASS_MSB + 1
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       start,
    input  wire logic [IMEM_ADDR_WIDTH-1:0] instruction_count,
    inst_dispatcher_if.master               bus,
    output logic      [IMEM_ADDR_WIDTH-1:0] program_counter,
    output logic                            busy,
    output logic                            done
);

    disp_state_e                state_q, state_d;
    logic [IMEM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [IMEM_ADDR_WIDTH-1:0] count_q, count_d;
    logic [INST_WIDTH-1:0]      inst_q, inst_d;

    inst_class_e w_held_class;
    inst_class_e w_rd_class;
    logic        w_pe_valid;
    logic        w_buf_valid;
    logic        w_fire;
    logic        w_last;

    assign w_held_class = inst_class_e'(inst_q[INST_WIDTH-1 -: CLASS_W]);
    assign w_rd_class   = inst_class_e'(bus.imem_rdata[INST_WIDTH-1 -: CLASS_W]);

    // Valids come from registered state only, so they never follow ready.
    assign w_pe_valid  = (state_q == ST_ISSUE) && (w_held_class == CLS_PE);
    assign w_buf_valid = (state_q == ST_ISSUE) && (w_held_class == CLS_BUF);
    assign w_fire      = (w_pe_valid && bus.pe_inst_ready) ||
                         (w_buf_valid && bus.buf_inst_ready);
    assign w_last      = (pc_q == count_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        inst_d  = inst_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    count_d = instruction_count;
                    pc_d    = '0;
                    state_d = (instruction_count == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                inst_d = bus.imem_rdata;
                pc_d   = pc_q + 1'b1;
                case (w_rd_class)
                    CLS_SYNC: state_d = ST_SYNC_WAIT;
                    CLS_HALT: state_d = ST_DONE;
                    default:  state_d = ST_ISSUE;
                endcase
            end
            ST_ISSUE: begin
                if (w_fire) state_d = w_last ? ST_DONE : ST_FETCH;
            end
            ST_SYNC_WAIT: begin
                if (bus.pe_idle && bus.buf_idle) state_d = w_last ? ST_DONE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            count_q <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            inst_q  <= inst_d;
        end
    end

    assign bus.imem_rd_en     = (state_q == ST_FETCH);
    assign bus.imem_addr      = pc_q;
    assign bus.pe_inst_valid  = w_pe_valid;
    assign bus.buf_inst_valid = w_buf_valid;
    assign bus.inst_data      = inst_q;
    assign program_counter    = pc_q;
    assign busy               = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done               = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_inst_dispatcher.sv
// ============================================================================
// tb_inst_dispatcher : directed-vector bench for inst_dispatcher -- Rev 1.0
// ============================================================================
`default_nettype none
module tb_inst_dispatcher;

    localparam int c_AW = 8;
    localparam int c_IW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [c_AW-1:0] instruction_count;
    logic [c_AW-1:0] program_counter;
    logic            busy;
    logic            done;

    logic [c_IW-1:0] mem [0:(1<<c_AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    inst_dispatcher_if #(.IMEM_ADDR_WIDTH(c_AW), .INST_WIDTH(c_IW)) bus ();

    inst_dispatcher #(.IMEM_ADDR_WIDTH(c_AW), .INST_WIDTH(c_IW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .instruction_count (instruction_count),
        .bus               (bus),
        .program_counter   (program_counter),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data one cycle after rd_en.
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start is sampled at E0; the count input is then scrambled to prove it was latched.
    task automatic do_start(input logic [c_AW-1:0] cnt);
        @(negedge clk);
        start = 1'b1;
        instruction_count = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        instruction_count = 8'hAA;
    endtask

    logic [15:0]     pe_seen, buf_seen, done_seen, rd_seen;
    logic [c_IW-1:0] data_snap;
    int              bad_data, issues, addr2_reads, activity;
    logic [c_AW-1:0] first_addr;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        instruction_count = '0;
        bus.imem_rdata = '0;
        bus.pe_inst_ready = 1'b1;
        bus.buf_inst_ready = 1'b1;
        bus.pe_idle = 1'b1;
        bus.buf_idle = 1'b1;
        for (int i = 0; i < (1 << c_AW); i++) mem[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_pc", program_counter, 0);
        check("rst_valids", {bus.pe_inst_valid, bus.buf_inst_valid}, 0);
        check("rst_rd_en", bus.imem_rd_en, 0);
        check("rst_inst_data", bus.inst_data, 0);
        rst_n = 1'b1;

        // Straight-line PE, BUF, PE
        mem[0] = 32'h0000_1111; mem[1] = 32'h4000_2222; mem[2] = 32'h0000_3333;
        do_start(8'd3);
        pe_seen = '0; buf_seen = '0; done_seen = '0; data_snap = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            pe_seen[c] = bus.pe_inst_valid;
            buf_seen[c] = bus.buf_inst_valid;
            done_seen[c] = done;
            if (c == 6) data_snap = bus.inst_data;
        end
        check("t1_pe_cycles", pe_seen, 16'h0208);
        check("t1_buf_cycles", buf_seen, 16'h0040);
        check("t1_done_cycles", done_seen, 16'h1C00);
        check("t1_buf_payload", data_snap, 32'h4000_2222);
        check("t1_pc", program_counter, 3);
        check("t1_busy", busy, 0);

        // Backpressure, with a stray start mid-issue that must be ignored
        mem[0] = 32'h0000_5A5A;
        bus.pe_inst_ready = 1'b0;
        do_start(8'd1);
        pe_seen = '0; buf_seen = '0; done_seen = '0; bad_data = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 8) bus.pe_inst_ready = 1'b1;
            if (c == 5) begin start = 1'b1; instruction_count = 8'd7; end
            if (c == 6) start = 1'b0;
            pe_seen[c] = bus.pe_inst_valid;
            buf_seen[c] = bus.buf_inst_valid;
            done_seen[c] = done;
            if (bus.pe_inst_valid && bus.inst_data !== 32'h0000_5A5A) bad_data++;
        end
        check("t2_pe_cycles", pe_seen, 16'h01F8);
        check("t2_buf_never", buf_seen, 0);
        check("t2_data_stable", bad_data, 0);
        check("t2_done_cycles", done_seen, 16'h1E00);
        check("t2_pc", program_counter, 1);

        // SYNC barrier: PE, SYNC, BUF with pe_idle low for cycles 4..7
        mem[0] = 32'h0000_0001; mem[1] = 32'h8000_0000; mem[2] = 32'h4000_0002;
        do_start(8'd3);
        pe_seen = '0; buf_seen = '0; done_seen = '0; rd_seen = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.pe_idle = !(c >= 4 && c <= 7);
            rd_seen[c] = bus.imem_rd_en;
            pe_seen[c] = bus.pe_inst_valid;
            buf_seen[c] = bus.buf_inst_valid;
            done_seen[c] = done;
        end
        bus.pe_idle = 1'b1;
        check("t3_fetch_cycles", rd_seen, 16'h0212);
        check("t3_pe_cycles", pe_seen, 16'h0008);
        check("t3_buf_cycles", buf_seen, 16'h0800);
        check("t3_done_cycles", done_seen, 16'h7000);

        // SYNC as the final instruction still waits for idle
        mem[0] = 32'h8000_0000;
        bus.buf_idle = 1'b0;
        do_start(8'd1);
        done_seen = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.buf_idle = (c >= 6);
            done_seen[c] = done;
        end
        bus.buf_idle = 1'b1;
        check("t3b_sync_last_done", done_seen, 16'h0180);

        // Early HALT at address 1 of a 4-instruction program
        mem[0] = 32'h4000_4444; mem[1] = 32'hC000_0000; mem[2] = 32'h0000_4545;
        do_start(8'd4);
        done_seen = '0; issues = 0; addr2_reads = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if ((bus.pe_inst_valid && bus.pe_inst_ready) ||
                (bus.buf_inst_valid && bus.buf_inst_ready)) issues++;
            if (bus.imem_rd_en && bus.imem_addr == 8'd2) addr2_reads++;
            done_seen[c] = done;
        end
        check("t4_done_cycles", done_seen, 16'h07C0);
        check("t4_pc", program_counter, 2);
        check("t4_issues", issues, 1);
        check("t4_addr2_reads", addr2_reads, 0);

        // Asynchronous reset while a PE instruction is held
        mem[0] = 32'h0000_6666;
        bus.pe_inst_ready = 1'b0;
        do_start(8'd1);
        repeat (4) @(negedge clk);
        check("t6_valid_before_rst", bus.pe_inst_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valids_in_rst", {bus.pe_inst_valid, bus.buf_inst_valid}, 0);
        check("t6_data_in_rst", bus.inst_data, 0);
        check("t6_pc_in_rst", program_counter, 0);
        check("t6_status_in_rst", {busy, done, bus.imem_rd_en}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pe_inst_ready = 1'b1;
        activity = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (busy || done || bus.imem_rd_en) activity++;
        end
        check("t6_idle_after_rst", activity, 0);

        // Zero count from IDLE, then restart with count=2
        do_start(8'd0);
        activity = 0;
        @(negedge clk);
        check("t5_zero_done", done, 1);
        for (int c = 1; c <= 3; c++) begin
            if (bus.imem_rd_en) activity++;
            @(negedge clk);
        end
        check("t5_zero_no_fetch", activity, 0);
        mem[0] = 32'h0000_7777; mem[1] = 32'h4000_8888;
        do_start(8'd2);
        done_seen = '0; first_addr = 8'hFF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1 && bus.imem_rd_en) first_addr = bus.imem_addr;
            done_seen[c] = done;
        end
        check("t5_restart_addr", first_addr, 0);
        check("t5_restart_done", done_seen, 16'h0180);
        check("t5_restart_pc", program_counter, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
